wbus_ram_slave: RTL and testbench

WBUS_RAM_SLAVE -- requirements
Module: wbus_ram_slave

---
 rtl/wbus_pkg.sv | 22 ++
 rtl/wbus_ram_array.sv | 41 ++++
 rtl/wbus_ram_slave.sv | 132 +++++++++++++
 tb/tb_wbus_ram_slave.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wbus_pkg.sv
// Shared W-bus definitions: bus widths, region codes and the RAM slave state encoding.
package wbus_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    localparam logic [3:0] WB_REGION_RAM = 4'h1;
    localparam logic [3:0] WB_REGION_IO  = 4'h2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } wbus_state_e;

    function automatic logic [3:0] region_of(input logic [WB_ADDR_W-1:0] addr);
        return addr[WB_ADDR_W-1 -: 4];
    endfunction

endpackage

// File: rtl/wbus_ram_array.sv
// Word-organised storage: synchronous byte-enabled write, registered read port.
module wbus_ram_array
    import wbus_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [ADDR_W-1:0]    idx_i,
    input  logic [WB_SEL_W-1:0]  be_i,
    input  logic [WB_DATA_W-1:0] wdata_i,
    output logic [WB_DATA_W-1:0] rdata_o
);

    logic [WB_DATA_W-1:0] mem_q [2**ADDR_W];
    logic [WB_DATA_W-1:0] rdata_q;

    // Contents are deliberately left unreset; only the read register clears.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < WB_SEL_W; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wbus_ram_slave.sv
// W-bus RAM slave with wait states and 4-phase handshake.
// Optional byte-lane writes via W_SEL when WBUS_RAM_BYTE_SEL_EN is defined.
module wbus_ram_slave
    import wbus_pkg::*;
#(
    parameter logic [3:0] BASE        = WB_REGION_RAM,
    parameter int         ADDR_W      = 10,
    parameter int         WAIT_STATES = 1
) (
    input  logic                 W_CLK,
    input  logic                 W_RST_N,
    input  logic                 W_REQ,
    input  logic                 W_WRITE,
    input  logic [WB_ADDR_W-1:0] W_ADDR,
    input  logic [WB_DATA_W-1:0] W_DATA_I,
`ifdef WBUS_RAM_BYTE_SEL_EN
    input  logic [WB_SEL_W-1:0]  W_SEL,
`endif
    output logic [WB_DATA_W-1:0] W_DATA_O,
    output logic                 W_ACK,
    output logic                 W_ERR
);

    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wbus_state_e          state_q;
    logic [3:0]           cnt_q;
    logic                 ack_q, err_q, rd_zero_q;
    logic [WB_ADDR_W-1:0] addr_q;
    logic                 write_q;
    logic [WB_DATA_W-1:0] data_q;
    logic [WB_DATA_W-1:0] rdata;

    logic                 accept, to_ack, hit, upper_zero;
    logic                 mem_we, mem_re;
    logic [WB_ADDR_W-1:0] cur_addr;
    logic                 cur_write;
    logic [WB_DATA_W-1:0] cur_data;
    logic [WB_SEL_W-1:0]  cur_sel;
    logic                 unused_lanes;

    // In IDLE the request is being accepted this edge, so use the live bus;
    // afterwards the captured copy is authoritative.
    assign accept    = W_RST_N && (state_q == ST_IDLE) && W_REQ;
    assign cur_addr  = (state_q == ST_IDLE) ? W_ADDR   : addr_q;
    assign cur_write = (state_q == ST_IDLE) ? W_WRITE  : write_q;
    assign cur_data  = (state_q == ST_IDLE) ? W_DATA_I : data_q;

`ifdef WBUS_RAM_BYTE_SEL_EN
    logic [WB_SEL_W-1:0] sel_q;
    assign cur_sel = (state_q == ST_IDLE) ? W_SEL : sel_q;
    always_ff @(posedge W_CLK) begin
        if (accept) sel_q <= W_SEL;
    end
`else
    assign cur_sel = '1;
`endif

    assign upper_zero   = (cur_addr[27:0] >> (ADDR_W + 2)) == '0;
    assign hit          = (region_of(cur_addr) == BASE) && upper_zero;
    assign unused_lanes = ^cur_addr[1:0];

    assign to_ack = (accept && (WAIT_STATES == 0))
                 || (W_RST_N && (state_q == ST_WAIT) && W_REQ && (cnt_q == WAIT_LAST));
    assign mem_we = to_ack && cur_write && hit;
    assign mem_re = to_ack && !cur_write && hit;

    always_ff @(posedge W_CLK) begin
        if (accept) begin
            addr_q  <= W_ADDR;
            write_q <= W_WRITE;
            data_q  <= W_DATA_I;
        end
    end

    always_ff @(posedge W_CLK or negedge W_RST_N) begin
        if (!W_RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (to_ack) begin
                ack_q <= 1'b1;
                err_q <= !hit;
                if (!cur_write) rd_zero_q <= !hit;
            end
            case (state_q)
                ST_IDLE: begin
                    if (W_REQ) begin
                        cnt_q   <= 4'd0;
                        state_q <= (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!W_REQ) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == WAIT_LAST) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_ACK:  state_q <= ST_DONE;
                ST_DONE: if (!W_REQ) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    wbus_ram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk_i   (W_CLK),
        .rst_ni  (W_RST_N),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .idx_i   (cur_addr[ADDR_W+1:2]),
        .be_i    (cur_sel),
        .wdata_i (cur_data),
        .rdata_o (rdata)
    );

    // Miss reads return zero without disturbing the stored read register.
    assign W_DATA_O = rd_zero_q ? '0 : rdata;
    assign W_ACK    = ack_q;
    assign W_ERR    = err_q;

endmodule

// File: tb/tb_wbus_ram_slave.sv
// Self-checking bench: three slaves (0, 1 and 3 wait states) share one bus stimulus.
module tb_wbus_ram_slave;

    logic        W_CLK = 1'b0;
    logic        W_RST_N;
    logic        W_REQ;
    logic        W_WRITE;
    logic [31:0] W_ADDR;
    logic [31:0] W_DATA_I;
`ifdef WBUS_RAM_BYTE_SEL_EN
    logic [3:0]  W_SEL;
`endif
    logic [2:0]  ack_w, err_w;
    logic [31:0] dat_w [3];

    always #5 W_CLK = ~W_CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wbus_ram_slave #(
            .BASE(4'h1), .ADDR_W(10),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .W_CLK    (W_CLK),
            .W_RST_N  (W_RST_N),
            .W_REQ    (W_REQ),
            .W_WRITE  (W_WRITE),
            .W_ADDR   (W_ADDR),
            .W_DATA_I (W_DATA_I),
`ifdef WBUS_RAM_BYTE_SEL_EN
            .W_SEL    (W_SEL),
`endif
            .W_DATA_O (dat_w[g]),
            .W_ACK    (ack_w[g]),
            .W_ERR    (err_w[g])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem_m [3][1024];
    logic [31:0] last_rd [3];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[$];

    function automatic int ws_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s ack u%0d", tag, k), 32'(ack_w[k]), 32'd0);
            chk($sformatf("%s err u%0d", tag, k), 32'(err_w[k]), 32'd0);
            chk($sformatf("%s data u%0d", tag, k), dat_w[k], 32'd0);
        end
    endtask

    // Full 4-phase transaction; the request is held until every slave has
    // answered plus 'hold' extra cycles. Returns what the 1-wait-state slave gave.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel, input int hold, input bit scramble,
                       input string tag, output logic [31:0] d1, output logic e1);
        bit          hit;
        int          idx;
        int          lat[3], nack[3], viol;
        logic [31:0] dq[3], expd[3];
        logic        eq[3];
        logic [3:0]  es;
`ifdef WBUS_RAM_BYTE_SEL_EN
        es = sel;
`else
        es = 4'hF | sel;
`endif
        hit = (addr[31:28] == 4'h1) && (addr[27:12] == 16'h0);
        idx = int'(addr[11:2]);
        for (int k = 0; k < 3; k++) begin
            if (wr) begin
                expd[k] = last_rd[k];
                if (hit) mem_m[k][idx] = merge(mem_m[k][idx], data, es);
            end else begin
                expd[k]    = hit ? mem_m[k][idx] : 32'd0;
                last_rd[k] = expd[k];
            end
            lat[k] = 0; nack[k] = 0; dq[k] = 'x; eq[k] = 1'bx;
        end
        viol = 0;
        W_WRITE  = wr;
        W_ADDR   = addr;
        W_DATA_I = data;
`ifdef WBUS_RAM_BYTE_SEL_EN
        W_SEL    = sel;
`endif
        W_REQ    = 1'b1;
        for (int c = 1; c <= 8 + hold; c++) begin
            @(posedge W_CLK); #1;
            for (int k = 0; k < 3; k++) begin
                if (ack_w[k]) begin
                    nack[k]++;
                    if (lat[k] == 0) begin
                        lat[k] = c; dq[k] = dat_w[k]; eq[k] = err_w[k];
                    end
                end else if (err_w[k]) begin
                    viol++;
                end
            end
            if (scramble && c == 1) begin
                W_ADDR  = $urandom;
                W_WRITE = ~wr;
            end
        end
        W_REQ = 1'b0;
        @(posedge W_CLK); #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s ack count u%0d", tag, k), 32'(nack[k] + int'(ack_w[k])), 32'd1);
            chk($sformatf("%s latency u%0d", tag, k), 32'(lat[k]), 32'(1 + ws_of(k)));
            chk($sformatf("%s err u%0d", tag, k), 32'(eq[k]), 32'(!hit));
            chk($sformatf("%s rdata u%0d", tag, k), dq[k], expd[k]);
        end
        chk($sformatf("%s err without ack", tag), 32'(viol), 32'd0);
        d1 = dq[1];
        e1 = eq[1];
    endtask

    initial begin
        logic [31:0] d1;
        logic        e1;
        int          n3;

        W_RST_N = 1'b1; W_REQ = 1'b0; W_WRITE = 1'b0; W_ADDR = '0; W_DATA_I = '0;
`ifdef WBUS_RAM_BYTE_SEL_EN
        W_SEL = 4'hF;
`endif
        for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
        #1 W_RST_N = 1'b0;
        repeat (2) @(posedge W_CLK);
        #1;
        chk_idle_outputs("reset");
        W_RST_N = 1'b1;
        @(posedge W_CLK); #1;

        vecs.push_back('{1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0000});
        vecs.push_back('{0, 32'h1000_0004, 32'h0,         4'hF, 0, 32'hDEAD_BEEF});
        vecs.push_back('{1, 32'h1000_0000, 32'hCAFE_F00D, 4'hF, 0, 32'hDEAD_BEEF});
        vecs.push_back('{0, 32'h2000_0000, 32'h0,         4'hF, 1, 32'h0000_0000});
        vecs.push_back('{0, 32'h1000_0000, 32'h0,         4'hF, 0, 32'hCAFE_F00D});
        vecs.push_back('{1, 32'h2000_0000, 32'h0000_5555, 4'hF, 1, 32'hCAFE_F00D});
        vecs.push_back('{0, 32'h1000_0003, 32'h0,         4'hF, 0, 32'hCAFE_F00D});
        vecs.push_back('{1, 32'h1000_1000, 32'h0000_0077, 4'hF, 1, 32'hCAFE_F00D});
        vecs.push_back('{0, 32'h1000_0000, 32'h0,         4'hF, 0, 32'hCAFE_F00D});
        vecs.push_back('{1, 32'h1000_0FFC, 32'h0BAD_F00D, 4'hF, 0, 32'hCAFE_F00D});
        vecs.push_back('{0, 32'h1000_0FFC, 32'h0,         4'hF, 0, 32'h0BAD_F00D});
`ifdef WBUS_RAM_BYTE_SEL_EN
        vecs.push_back('{1, 32'h1000_0014, 32'h1122_3344, 4'hF, 0, 32'h0BAD_F00D});
        vecs.push_back('{1, 32'h1000_0014, 32'hAABB_CCDD, 4'h5, 0, 32'h0BAD_F00D});
        vecs.push_back('{0, 32'h1000_0014, 32'h0,         4'hF, 0, 32'h11BB_33DD});
        vecs.push_back('{1, 32'h1000_0014, 32'hFFFF_FFFF, 4'h0, 0, 32'h11BB_33DD});
        vecs.push_back('{0, 32'h1000_0014, 32'h0,         4'hF, 0, 32'h11BB_33DD});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].sel, 0, 1'b0,
                $sformatf("vec%0d", i), d1, e1);
            chk($sformatf("vec%0d table err", i), 32'(e1), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d table rdata", i), d1, vecs[i].exp_rdata);
        end

        // Request held for 10 cycles after the acknowledge: served once only.
        txn(1'b0, 32'h1000_0004, 32'h0, 4'hF, 10, 1'b0, "held_req", d1, e1);
        chk("held_req table rdata", d1, 32'hDEAD_BEEF);

        for (int w = 0; w < 8; w++)
            txn(1'b1, 32'h1000_0000 + 32'(4 * w), $urandom, 4'hF, 0, 1'b0,
                $sformatf("init%0d", w), d1, e1);
        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
            else if (kind == 1) a = 32'h1000_1000 | ($urandom & 32'h00FF_FFFF);
            else                a = 32'h1000_0000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
                1'($urandom), $sformatf("rnd%0d", i), d1, e1);
        end

        // Reset while the waiting slaves hold an uncommitted write.
        W_WRITE = 1'b1; W_ADDR = 32'h1000_0008; W_DATA_I = 32'h1234_5678;
`ifdef WBUS_RAM_BYTE_SEL_EN
        W_SEL = 4'hF;
`endif
        W_REQ = 1'b1;
        @(posedge W_CLK); #1;
        chk("rst_mid ack u1 before reset", 32'(ack_w[1]), 32'd0);
        chk("rst_mid ack u3 before reset", 32'(ack_w[2]), 32'd0);
        W_RST_N = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        W_REQ = 1'b0;
        repeat (2) @(posedge W_CLK);
        #1;
        W_RST_N = 1'b1;
        mem_m[0][2] = 32'h1234_5678;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
        @(posedge W_CLK); #1;
        chk("rst_mid ack after release", 32'(|ack_w), 32'd0);
        txn(1'b0, 32'h1000_0008, 32'h0, 4'hF, 0, 1'b0, "rst_mid readback", d1, e1);

        // Request dropped while the 3-wait-state slave is still waiting.
        W_WRITE = 1'b1; W_ADDR = 32'h1000_0010; W_DATA_I = 32'hFEED_FACE;
`ifdef WBUS_RAM_BYTE_SEL_EN
        W_SEL = 4'hF;
`endif
        W_REQ = 1'b1;
        n3 = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge W_CLK); #1;
            n3 += int'(ack_w[2]);
            if (c == 2) W_REQ = 1'b0;
        end
        chk("abort ack u3", 32'(n3), 32'd0);
        mem_m[0][4] = 32'hFEED_FACE;
        mem_m[1][4] = 32'hFEED_FACE;
        txn(1'b0, 32'h1000_0010, 32'h0, 4'hF, 0, 1'b0, "abort readback", d1, e1);
        chk("abort readback table u1", d1, 32'hFEED_FACE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, limit 500000");
        $fatal(1);
    end

endmodule
